// File: rtl/mult_pkg.sv
// mult_pkg: shared types and defaults for the shift-add multiplier controller.
//   state_t    - controller FSM states (IDLE, LOAD, RUN, DONE)
//   N_BITS_DEF - default operand width (also the iterations per multiply)
package mult_pkg;

    localparam int N_BITS_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mult_iter_cnt.sv
// mult_iter_cnt: iteration counter plus datapath count_check cross-check.
// Ports:
//   clk, reset (async, active-low)
//   clear       - zero the counter (operand load cycle)
//   inc         - advance the counter by one (each issued strobe)
//   chk_en      - compare count_check against our own terminal this cycle
//   count_check - datapath counter terminal flag
//   terminal    - counter sits at N_BITS-1 (last iteration)
//   err         - sticky: datapath terminal disagreed with ours
module mult_iter_cnt
    import mult_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF,
    parameter int CNT_W  = $clog2(N_BITS)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    input  logic chk_en,
    input  logic count_check,
    output logic terminal,
    output logic err
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     cnt <= '0;
        else if (clear) cnt <= '0;
        else if (inc)   cnt <= cnt + 1'b1;
    end

    assign terminal = (cnt == CNT_W'(N_BITS - 1));

    // Datapath must flag terminal on exactly our last iteration: a late
    // flag and an early flag are both mismatches. Cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                err <= 1'b0;
        else if (chk_en && (terminal != count_check)) err <= 1'b1;
    end

endmodule

// File: rtl/mult_controller.sv
// mult_controller: sequencing FSM for an iterative shift-add multiplier.
// Ports:
//   clk, reset (async, active-low)
//   start       - begin a multiply (sampled in IDLE only)
//   mplier_lsb  - bit 0 of the datapath's shifting multiplier
//   mplier_zero - datapath multiplier register is all-zero
//   count_check - datapath counter terminal flag (cross-checked -> err)
//   ack         - consumer took the product (sampled in DONE only)
//   load_words  - operand load strobe (LOAD)
//   add_shift   - accumulate-and-shift strobe (RUN, lsb=1)
//   shift       - shift-only strobe (RUN, lsb=0)
//   ready       - idle, accepting start
//   done        - product valid, held until ack
//   err         - sticky iteration mismatch
// Build option: define MULT_EARLY_TERM_EN to leave RUN as soon as the
// multiplier register is zero (no strobe that cycle, no count_check check).
module mult_controller
    import mult_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF,
    parameter int CNT_W  = $clog2(N_BITS)
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic mplier_lsb,
    input  logic mplier_zero,
    input  logic count_check,
    input  logic ack,
    output logic load_words,
    output logic add_shift,
    output logic shift,
    output logic ready,
    output logic done,
    output logic err
);

    state_t state_q, state_d;
    logic   cnt_clear, cnt_inc, chk_en, terminal, early_term;

`ifdef MULT_EARLY_TERM_EN
    assign early_term = mplier_zero;
`else
    logic unused_mplier_zero;
    assign early_term         = 1'b0;
    assign unused_mplier_zero = mplier_zero;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Strobes depend on state, mplier_lsb (and mplier_zero when early
    // termination is built in); start/ack only steer next state.
    always_comb begin
        state_d    = state_q;
        load_words = 1'b0;
        add_shift  = 1'b0;
        shift      = 1'b0;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        chk_en     = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                load_words = 1'b1;
                cnt_clear  = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                if (early_term) begin
                    state_d = DONE;
                end else begin
                    add_shift = mplier_lsb;
                    shift     = ~mplier_lsb;
                    cnt_inc   = 1'b1;
                    chk_en    = 1'b1;
                    if (terminal) state_d = DONE;
                end
            end
            DONE: if (ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);

    mult_iter_cnt #(
        .N_BITS (N_BITS),
        .CNT_W  (CNT_W)
    ) u_iter_cnt (
        .clk         (clk),
        .reset       (reset),
        .clear       (cnt_clear),
        .inc         (cnt_inc),
        .chk_en      (chk_en),
        .count_check (count_check),
        .terminal    (terminal),
        .err         (err)
    );

endmodule

// File: tb/tb_mult_controller.sv
module tb_mult_controller;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0, mplier_lsb = 1'b0, mplier_zero = 1'b0;
    logic count_check = 1'b0, ack = 1'b0;
    logic load_words, add_shift, shift, ready, done, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult_controller #(.N_BITS(16), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mplier_lsb  (mplier_lsb),
        .mplier_zero (mplier_zero),
        .count_check (count_check),
        .ack         (ack),
        .load_words  (load_words),
        .add_shift   (add_shift),
        .shift       (shift),
        .ready       (ready),
        .done        (done),
        .err         (err)
    );

    // Datapath stand-in: presents multiplier bits per RUN cycle from the
    // fixed latency (LOAD at +1, RUN r at +2+r) and tallies what it saw.
    // cc_bad inverts count_check at that RUN index (99 = never).
    task automatic drive_op(input logic [15:0] m, input int cc_bad, input bit zero_en,
                            output int n_add, output int n_shift, output logic [15:0] add_mask,
                            output int n_load, output int multi, output int lat);
        logic [15:0] mm;
        int r;
        n_add = 0; n_shift = 0; add_mask = '0; n_load = 0; multi = 0; lat = -1;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            r = c - 2;
            mm = (r >= 0 && r < 16) ? (m >> r) : 16'h0;
            mplier_lsb  = mm[0];
            count_check = ((r == 15) != (r == cc_bad));
            mplier_zero = zero_en && (r >= 0) && (mm == 16'h0);
            @(negedge clk);
            if (done) begin lat = c; break; end
            if (load_words) n_load++;
            if (add_shift) begin
                n_add++;
                if (r >= 0 && r < 16) add_mask[4'(r)] = 1'b1;
            end
            if (shift) n_shift++;
            if ((int'(load_words) + int'(add_shift) + int'(shift)) > 1) multi++;
            @(posedge clk); #1;
        end
        mplier_lsb = 1'b0; count_check = 1'b0; mplier_zero = 1'b0;
    endtask

    task automatic do_ack();
        @(negedge clk); ack = 1'b1;
        @(posedge clk); #1; ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({ready, done, err, load_words, add_shift, shift} !== 6'b100000) begin
            bad++; $display("FAIL reset_vals: got %b want 100000", {ready, done, err, load_words, add_shift, shift});
        end
        // first edge after release must accept start
        @(posedge clk); #1; reset = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        total++;
        if ({load_words, ready} !== 2'b10) begin
            bad++; $display("FAIL first_start: got load/ready=%b want 10", {load_words, ready});
        end
        reset = 1'b0; #1;
        total++;
        if ({ready, load_words, add_shift, shift} !== 4'b1000) begin
            bad++; $display("FAIL reset_in_load: got %b want 1000", {ready, load_words, add_shift, shift});
        end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_mult_5();
        int na, ns, nl, mu, lat; logic [15:0] msk;
        drive_op(16'h0005, 99, 1'b0, na, ns, msk, nl, mu, lat);
        total++; if (lat !== 18) begin bad++; $display("FAIL m5_latency: got %0d want 18", lat); end
        total++; if (na !== 2) begin bad++; $display("FAIL m5_add_count: got %0d want 2", na); end
        total++; if (msk !== 16'h0005) begin bad++; $display("FAIL m5_add_mask: got %h want 0005", msk); end
        total++; if (ns !== 14) begin bad++; $display("FAIL m5_shift_count: got %0d want 14", ns); end
        total++; if (nl !== 1) begin bad++; $display("FAIL m5_load_count: got %0d want 1", nl); end
        total++; if (mu !== 0) begin bad++; $display("FAIL m5_exclusive: got %0d want 0", mu); end
        total++;
        if ({done, ready, err} !== 3'b100) begin
            bad++; $display("FAIL m5_done_state: got done/ready/err=%b want 100", {done, ready, err});
        end
        do_ack();
        total++;
        if ({ready, done} !== 2'b10) begin bad++; $display("FAIL m5_ack_idle: got %b want 10", {ready, done}); end
    endtask

    task automatic test_mult_ffff();
        int na, ns, nl, mu, lat; logic [15:0] msk;
        drive_op(16'hFFFF, 99, 1'b0, na, ns, msk, nl, mu, lat);
        total++; if (na !== 16) begin bad++; $display("FAIL ffff_add_count: got %0d want 16", na); end
        total++; if (ns !== 0) begin bad++; $display("FAIL ffff_shift_count: got %0d want 0", ns); end
        total++; if (msk !== 16'hFFFF) begin bad++; $display("FAIL ffff_add_mask: got %h want ffff", msk); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL ffff_err: got %b want 0", err); end
        do_ack();
    endtask

    task automatic test_back_to_back();
        int na, ns, nl, mu, lat; logic [15:0] msk;
        drive_op(16'h1234, 99, 1'b0, na, ns, msk, nl, mu, lat);
        total++; if (na !== 5) begin bad++; $display("FAIL b2b1_add_count: got %0d want 5", na); end
        total++; if (ns !== 11) begin bad++; $display("FAIL b2b1_shift_count: got %0d want 11", ns); end
        do_ack();
        drive_op(16'hA5A5, 99, 1'b0, na, ns, msk, nl, mu, lat);
        total++; if (lat !== 18) begin bad++; $display("FAIL b2b2_latency: got %0d want 18", lat); end
        total++; if (msk !== 16'hA5A5) begin bad++; $display("FAIL b2b2_add_mask: got %h want a5a5", msk); end
        total++; if (ns !== 8) begin bad++; $display("FAIL b2b2_shift_count: got %0d want 8", ns); end
        do_ack();
    endtask

    task automatic test_reset_mid();
        int na, ns, nl, mu, lat; logic [15:0] msk;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (8) @(posedge clk);
        #1; mplier_lsb = 1'b1; count_check = 1'b0;
        #1;
        total++; if (add_shift !== 1'b1) begin bad++; $display("FAIL rmid_run7_add: got %b want 1", add_shift); end
        reset = 1'b0; #1;
        total++;
        if ({ready, done, load_words, add_shift, shift} !== 5'b10000) begin
            bad++; $display("FAIL rmid_async: got %b want 10000", {ready, done, load_words, add_shift, shift});
        end
        @(negedge clk); reset = 1'b1; mplier_lsb = 1'b0;
        drive_op(16'h00F0, 99, 1'b0, na, ns, msk, nl, mu, lat);
        total++; if (lat !== 18) begin bad++; $display("FAIL rmid_latency: got %0d want 18", lat); end
        total++; if (msk !== 16'h00F0) begin bad++; $display("FAIL rmid_add_mask: got %h want 00f0", msk); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rmid_err: got %b want 0", err); end
        do_ack();
    endtask

    task automatic test_ack_hold();
        int na, ns, nl, mu, lat; logic [15:0] msk;
        drive_op(16'h8001, 99, 1'b0, na, ns, msk, nl, mu, lat);
        total++; if (msk !== 16'h8001) begin bad++; $display("FAIL hold_add_mask: got %h want 8001", msk); end
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0) start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk);
            total++;
            if ({done, ready, load_words, add_shift, shift} !== 5'b10000) begin
                bad++; $display("FAIL hold_cycle%0d: got %b want 10000", i, {done, ready, load_words, add_shift, shift});
            end
        end
        do_ack();
        total++; if ({ready, done} !== 2'b10) begin bad++; $display("FAIL hold_ack_idle: got %b want 10", {ready, done}); end
        @(negedge clk);
        total++;
        if ({ready, load_words} !== 2'b10) begin bad++; $display("FAIL hold_no_stale_start: got %b want 10", {ready, load_words}); end
    endtask

    task automatic test_ack_start();
        int na, ns, nl, mu, lat; logic [15:0] msk;
        drive_op(16'h0001, 99, 1'b0, na, ns, msk, nl, mu, lat);
        ack = 1'b1; start = 1'b1;
        @(posedge clk); #1; ack = 1'b0; start = 1'b0;
        @(negedge clk);
        total++;
        if ({ready, done, load_words} !== 3'b100) begin
            bad++; $display("FAIL ackstart_idle: got %b want 100", {ready, done, load_words});
        end
        @(negedge clk);
        total++;
        if ({ready, load_words} !== 2'b10) begin bad++; $display("FAIL ackstart_not_taken: got %b want 10", {ready, load_words}); end
    endtask

`ifdef MULT_EARLY_TERM_EN
    task automatic test_early_term();
        int na, ns, nl, mu, lat; logic [15:0] msk;
        drive_op(16'h0003, 99, 1'b1, na, ns, msk, nl, mu, lat);
        total++; if (na !== 2) begin bad++; $display("FAIL early_add_count: got %0d want 2", na); end
        total++; if (ns !== 0) begin bad++; $display("FAIL early_shift_count: got %0d want 0", ns); end
        total++; if (lat !== 5) begin bad++; $display("FAIL early_latency: got %0d want 5", lat); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL early_err: got %b want 0", err); end
        do_ack();
    endtask
`endif

    task automatic test_err_final();
        int na, ns, nl, mu, lat; logic [15:0] msk;
        drive_op(16'h0F0F, 15, 1'b0, na, ns, msk, nl, mu, lat);
        total++; if (lat !== 18) begin bad++; $display("FAIL errfin_latency: got %0d want 18", lat); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL errfin_set: got %b want 1", err); end
        do_ack();
        drive_op(16'h0005, 99, 1'b0, na, ns, msk, nl, mu, lat);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL errfin_sticky: got %b want 1", err); end
        do_ack();
    endtask

    task automatic test_err_early();
        int na, ns, nl, mu, lat; logic [15:0] msk;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL errearly_reset_clear: got %b want 0", err); end
        reset = 1'b1;
        drive_op(16'h0005, 5, 1'b0, na, ns, msk, nl, mu, lat);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL errearly_set: got %b want 1", err); end
        total++; if (lat !== 18) begin bad++; $display("FAIL errearly_latency: got %0d want 18", lat); end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_mult_5();
        test_mult_ffff();
        test_back_to_back();
        test_reset_mid();
        test_ack_hold();
        test_ack_start();
`ifdef MULT_EARLY_TERM_EN
        test_early_term();
`endif
        test_err_final();
        test_err_early();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
